// File: rtl/pixel_on_segment_pipe.sv
`default_nettype none
// ============================================================================
// Module : pixel_on_segment_pipe
// Streaming pixel-on-segment/arrowhead tester with per-segment hit counter.
// Rev    : 1.0
// ============================================================================
module pixel_on_segment_pipe #(
    parameter int W          = 32,
    parameter int FRAC       = 16,
    parameter int LINE_WIDTH = 5,
    parameter int HEAD_LEN   = 5,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [W-1:0]     cfg_x0,
    input  logic [W-1:0]     cfg_y0,
    input  logic [W-1:0]     cfg_xn,
    input  logic [W-1:0]     cfg_yn,
    input  logic [W-1:0]     cfg_mag,
    input  logic             cfg_arrow_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic             out_head,
    output logic [CNT_W-1:0] hit_count
);
    localparam logic signed [W-1:0] C_LW2  = W'(LINE_WIDTH * LINE_WIDTH) << FRAC;
    localparam logic signed [W-1:0] C_HEAD = W'(HEAD_LEN) << FRAC;

    function automatic logic signed [W-1:0] fx(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = a * b;
        return W'(p >>> FRAC);
    endfunction

    logic signed [W-1:0] x0_q, x0_d, y0_q, y0_d, xn_q, xn_d, yn_q, yn_d, mag_q, mag_d;
    logic                arrow_en_q, arrow_en_d;
    logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [W-1:0] x1_q, x1_d, y1_q, y1_d, dx1_q, dx1_d, dy1_q, dy1_d;
    logic signed [W-1:0] x2_q, x2_d, y2_q, y2_d, t2_q, t2_d;
    logic signed [W-1:0] ex3_q, ex3_d, ey3_q, ey3_d, t3_q, t3_d, r3_q, r3_d;
    logic                out_valid_q, out_valid_d, out_hit_q, out_hit_d, out_head_q, out_head_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;

    logic                adv, cfg_load, accept;
    logic signed [W-1:0] d2, px, py;
    logic                in_rng, head_zone, head_hit;

    assign adv       = !out_valid_q || out_ready;
    assign cfg_ready = !(v1_q || v2_q || v3_q || out_valid_q);
    assign cfg_load  = cfg_valid && cfg_ready;
    assign in_ready  = adv && !cfg_load;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_head  = out_head_q;
    assign hit_count = hit_count_q;

    always_comb begin
        px        = x0_q + fx(xn_q, t2_q);
        py        = y0_q + fx(yn_q, t2_q);
        d2        = fx(ex3_q, ex3_q) + fx(ey3_q, ey3_q);
        in_rng    = (t3_q >= 0) && (t3_q <= mag_q);
        // A short segment (mag < HEAD_LEN) makes this threshold negative, so the whole range is head.
        head_zone = arrow_en_q && (t3_q > (mag_q - C_HEAD));
        head_hit  = in_rng && head_zone && (d2 <= fx(r3_q, r3_q));
    end

    always_comb begin
        x0_d        = x0_q;
        y0_d        = y0_q;
        xn_d        = xn_q;
        yn_d        = yn_q;
        mag_d       = mag_q;
        arrow_en_d  = arrow_en_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        v3_d        = v3_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        dx1_d       = dx1_q;
        dy1_d       = dy1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        t2_d        = t2_q;
        ex3_d       = ex3_q;
        ey3_d       = ey3_q;
        t3_d        = t3_q;
        r3_d        = r3_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_head_d  = out_head_q;
        hit_count_d = hit_count_q;

        if (cfg_load) begin
            x0_d        = cfg_x0;
            y0_d        = cfg_y0;
            xn_d        = cfg_xn;
            yn_d        = cfg_yn;
            mag_d       = cfg_mag;
            arrow_en_d  = cfg_arrow_en;
            hit_count_d = '0;
        end else if (out_valid_q && out_ready && out_hit_q && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 1'b1;
        end

        // Every stage moves together, so a stall freezes the whole pipe including the outputs.
        if (adv) begin
            v1_d        = accept;
            x1_d        = in_x;
            y1_d        = in_y;
            dx1_d       = in_x - x0_q;
            dy1_d       = in_y - y0_q;
            v2_d        = v1_q;
            x2_d        = x1_q;
            y2_d        = y1_q;
            t2_d        = fx(dx1_q, xn_q) + fx(dy1_q, yn_q);
            v3_d        = v2_q;
            ex3_d       = x2_q - px;
            ey3_d       = y2_q - py;
            t3_d        = t2_q;
            r3_d        = mag_q - t2_q;
            out_valid_d = v3_q;
            out_head_d  = v3_q && head_hit;
            out_hit_d   = v3_q && (head_hit || (in_rng && !head_zone && (d2 <= C_LW2)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q        <= '0;
            y0_q        <= '0;
            xn_q        <= '0;
            yn_q        <= '0;
            mag_q       <= '0;
            arrow_en_q  <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            x1_q        <= '0;
            y1_q        <= '0;
            dx1_q       <= '0;
            dy1_q       <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            t2_q        <= '0;
            ex3_q       <= '0;
            ey3_q       <= '0;
            t3_q        <= '0;
            r3_q        <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_head_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            xn_q        <= xn_d;
            yn_q        <= yn_d;
            mag_q       <= mag_d;
            arrow_en_q  <= arrow_en_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            dx1_q       <= dx1_d;
            dy1_q       <= dy1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            t2_q        <= t2_d;
            ex3_q       <= ex3_d;
            ey3_q       <= ey3_d;
            t3_q        <= t3_d;
            r3_q        <= r3_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_head_q  <= out_head_d;
            hit_count_q <= hit_count_d;
        end
    end
endmodule
`default_nettype wire
